// File: rtl/mmio_data_memory_v2.sv
// ============================================================================
// Module      : mmio_data_memory_v2
// Description : Word RAM with byte-enable writes plus memory-mapped board I/O
//               (HEX, LEDR, KEY with sticky edge capture and IRQ, SW, cycle counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_data_memory_v2 #(
    parameter              MEM_INIT_FILE       = "",
    parameter int unsigned DATA_BIT_WIDTH      = 32,
    parameter int unsigned TRUE_ADDR_BIT_WIDTH = 11,
    parameter int unsigned N_KEYS              = 4,
    parameter int unsigned N_SW                = 10,
    parameter int unsigned N_LEDR              = 10,
    parameter int unsigned HEX_WIDTH           = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wrtEn,
    input  logic [DATA_BIT_WIDTH/8-1:0] byteEn,
    input  logic [31:0]                 addr,
    input  logic [DATA_BIT_WIDTH-1:0]   dIn,
    input  logic [N_SW-1:0]             sw,
    input  logic [N_KEYS-1:0]           key,
    output logic [N_LEDR-1:0]           ledr,
    output logic [HEX_WIDTH-1:0]        hex,
    output logic [DATA_BIT_WIDTH-1:0]   dOut,
    output logic                        keyIrq
);

    localparam int unsigned N_WORDS = 1 << TRUE_ADDR_BIT_WIDTH;
    localparam int unsigned N_BYTES = DATA_BIT_WIDTH / 8;
    localparam logic [HEX_WIDTH-1:0] HEX_BLANK = HEX_WIDTH'(16'h0BAD);

    localparam logic [2:0] OFF_HEX     = 3'd0;
    localparam logic [2:0] OFF_LEDR    = 3'd1;
    localparam logic [2:0] OFF_KEY     = 3'd2;
    localparam logic [2:0] OFF_KEYEDGE = 3'd3;
    localparam logic [2:0] OFF_KEYMASK = 3'd4;
    localparam logic [2:0] OFF_SW      = 3'd5;
    localparam logic [2:0] OFF_CYCLES  = 3'd6;

    (* ram_init_file = MEM_INIT_FILE *)
    logic [DATA_BIT_WIDTH-1:0] mem [N_WORDS];

    logic                           io_sel;
    logic [TRUE_ADDR_BIT_WIDTH-1:0] word_idx;
    logic [2:0]                     io_off;
    logic                           io_we;
    logic                           ram_we;
    logic [DATA_BIT_WIDTH-1:0]      ram_rdata;
    logic [DATA_BIT_WIDTH-1:0]      io_rdata;
    logic [N_KEYS-1:0]              key_rise;
    logic [N_KEYS-1:0]              key_w1c;
    logic                           unused_addr_bits;

    logic [N_LEDR-1:0]         ledr_q,     ledr_d;
    logic [HEX_WIDTH-1:0]      hex_q,      hex_d;
    logic [DATA_BIT_WIDTH-1:0] dout_q,     dout_d;
    logic                      irq_q,      irq_d;
    logic [N_KEYS-1:0]         keyedge_q,  keyedge_d;
    logic [N_KEYS-1:0]         keymask_q,  keymask_d;
    logic [DATA_BIT_WIDTH-1:0] cycle_q,    cycle_d;
    logic [N_KEYS-1:0]         key_s1_q,   key_s1_d;
    logic [N_KEYS-1:0]         key_s2_q,   key_s2_d;
    logic [N_KEYS-1:0]         key_prev_q, key_prev_d;
    logic [N_SW-1:0]           sw_s1_q,    sw_s1_d;
    logic [N_SW-1:0]           sw_s2_q,    sw_s2_d;

    assign io_sel    = addr[29];
    assign word_idx  = addr[TRUE_ADDR_BIT_WIDTH+1:2];
    assign io_off    = addr[4:2];
    assign io_we     = wrtEn & io_sel;
    assign ram_we    = wrtEn & ~io_sel;
    assign ram_rdata = mem[word_idx];

    assign unused_addr_bits = &{1'b0, addr[31:30], addr[28:TRUE_ADDR_BIT_WIDTH+2], addr[1:0]};

    // Key pins are active-low: a press edge is released-last-cycle, pressed-now.
    assign key_rise = key_prev_q & ~key_s2_q;
    assign key_w1c  = (io_we && io_off == OFF_KEYEDGE) ? dIn[N_KEYS-1:0] : '0;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < N_BYTES; i++) begin
                if (byteEn[i]) begin
                    mem[word_idx][8*i +: 8] <= dIn[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_off)
            OFF_HEX:     io_rdata[HEX_WIDTH-1:0] = hex_q;
            OFF_LEDR:    io_rdata[N_LEDR-1:0]    = ledr_q;
            OFF_KEY:     io_rdata[N_KEYS-1:0]    = ~key_s2_q;
            OFF_KEYEDGE: io_rdata[N_KEYS-1:0]    = keyedge_q;
            OFF_KEYMASK: io_rdata[N_KEYS-1:0]    = keymask_q;
            OFF_SW:      io_rdata[N_SW-1:0]      = sw_s2_q;
            OFF_CYCLES:  io_rdata                = cycle_q;
            default:     io_rdata                = '0;
        endcase
    end

    always_comb begin
        ledr_d     = ledr_q;
        hex_d      = hex_q;
        keymask_d  = keymask_q;
        key_s1_d   = key;
        key_s2_d   = key_s1_q;
        key_prev_d = key_s2_q;
        sw_s1_d    = sw;
        sw_s2_d    = sw_s1_q;
        cycle_d    = cycle_q + DATA_BIT_WIDTH'(1);
        // Set has priority over a same-cycle clear.
        keyedge_d  = (keyedge_q & ~key_w1c) | key_rise;
        irq_d      = |(keyedge_q & keymask_q);
        dout_d     = io_sel ? io_rdata : ram_rdata;

        if (io_we) begin
            case (io_off)
                OFF_HEX:     hex_d     = (dIn[HEX_WIDTH-1:0] == HEX_BLANK) ? '0 : dIn[HEX_WIDTH-1:0];
                OFF_LEDR:    ledr_d    = dIn[N_LEDR-1:0];
                OFF_KEYMASK: keymask_d = dIn[N_KEYS-1:0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledr_q     <= '0;
            hex_q      <= '0;
            dout_q     <= '0;
            irq_q      <= 1'b0;
            keyedge_q  <= '0;
            keymask_q  <= '0;
            cycle_q    <= '0;
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            key_prev_q <= '1;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
        end else begin
            ledr_q     <= ledr_d;
            hex_q      <= hex_d;
            dout_q     <= dout_d;
            irq_q      <= irq_d;
            keyedge_q  <= keyedge_d;
            keymask_q  <= keymask_d;
            cycle_q    <= cycle_d;
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            key_prev_q <= key_prev_d;
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
        end
    end

    assign ledr   = ledr_q;
    assign hex    = hex_q;
    assign dOut   = dout_q;
    assign keyIrq = irq_q;

endmodule

`default_nettype wire
